// File: rtl/combi_ldm_seq_if.sv
// Decoder <-> LDM/STM sequencer bus: D-stage instruction context in, per-beat controls out.
interface combi_ldm_seq_if #(
   parameter int unsigned BEATW = 5
);
   logic [31:0]      instrD;
   logic             armD;
   logic             validD;
   logic             StallD;
   logic             FlushD;
   logic             ldmStall;
   logic             LdmActiveD;
   logic [3:0]       LdmRegD;
   logic [BEATW-1:0] LdmBeatD;
   logic             LdmFirstD;
   logic             LdmLastD;
   logic             LdmWbD;

   modport master (
      output instrD, armD, validD, StallD, FlushD,
      input  ldmStall, LdmActiveD, LdmRegD, LdmBeatD, LdmFirstD, LdmLastD, LdmWbD
   );

   modport slave (
      input  instrD, armD, validD, StallD, FlushD,
      output ldmStall, LdmActiveD, LdmRegD, LdmBeatD, LdmFirstD, LdmLastD, LdmWbD
   );
endinterface

// File: rtl/combi_ldm_seq.sv
// ARM LDM/STM decode-stage sequencer: emits one register-list beat per unstalled cycle
// and holds F/D via ldmStall until the last beat.
module combi_ldm_seq #(
   parameter int unsigned NREGS = 16,
   parameter int unsigned BEATW = 5
) (
   input logic             clk,
   input logic             rst,
   combi_ldm_seq_if.slave  ldm
);
   localparam int unsigned REGW = 4;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [NREGS-1:0] rem_q, rem_d;
   logic [BEATW-1:0] beat_q, beat_d;

   logic             is_bt;
   logic             active;
   logic             more;
   logic [NREGS-1:0] src;
   logic [REGW-1:0]  low_idx;
   logic [BEATW-1:0] beat_cur;
   logic             unused_instr;

   assign unused_instr = ^{ldm.instrD[31:28], ldm.instrD[24:22], ldm.instrD[20:16]};

   // Current beat: lowest set bit of the fresh list (IDLE) or the leftover mask (BUSY)
   always_comb begin
      is_bt   = ldm.armD & ldm.validD & (ldm.instrD[27:25] == 3'b100);
      src     = (state_q == BUSY) ? rem_q : NREGS'(ldm.instrD[15:0]);
      low_idx = '0;
      for (int i = NREGS - 1; i >= 0; i--) begin
         if (src[i]) low_idx = REGW'(i);
      end
      active   = is_bt & (src != '0);
      more     = (src & (src - NREGS'(1))) != '0;
      beat_cur = (active && state_q == BUSY) ? beat_q : '0;
   end

   // Next state: flush and lost-instruction abort beat stall; advance only when unstalled
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      beat_d  = beat_q;
      if (ldm.FlushD || (state_q == BUSY && !is_bt)) begin
         state_d = IDLE;
         rem_d   = '0;
         beat_d  = '0;
      end else if (!ldm.StallD && active) begin
         rem_d   = src & ~(NREGS'(1) << low_idx);
         beat_d  = beat_cur + BEATW'(1);
         state_d = more ? BUSY : IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rem_q   <= '0;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         beat_q  <= beat_d;
      end
   end

   assign ldm.LdmActiveD = active;
   assign ldm.LdmRegD    = active ? low_idx : '0;
   assign ldm.LdmBeatD   = beat_cur;
   assign ldm.ldmStall   = active & more;
   assign ldm.LdmFirstD  = active & (state_q == IDLE);
   assign ldm.LdmLastD   = active & ~more;
   assign ldm.LdmWbD     = active & ~more & ldm.instrD[21];

endmodule

// File: doc/combi_ldm_seq.md
Name: combi_ldm_seq

Overview:
- Decode-stage micro-op sequencer for ARM LDM/STM in the combined ARM/RISC-V core.
- Walks the 16-bit register list of a block-transfer instruction held in D, one register per cycle.
- Generates `ldmStall`, which feeds the combined decoder and holds F/D while beats remain.
- Supplies the per-beat register number, beat index and first/last markers to the decoder and the register-file read mux.

Parameters:
- NREGS, 16, width of the register list (ARM: 16 registers).
- BEATW, 5, width of the beat counter; must hold 0..NREGS.

Ports:
- clk  input  1  core clock.
- rst  input  1  reset; synchronous, active-high.
- instrD  input  32  instruction currently in the decode stage.
- armD  input  1  decode stage is in ARM mode.
- validD  input  1  D holds a non-flushed instruction.
- StallD  input  1  D stage stalled; the sequencer must not advance.
- FlushD  input  1  D stage flushed this cycle.
- ldmStall  output  1  more beats remain after the current one; F/D must hold.
- LdmActiveD  output  1  current D instruction is a block transfer emitting a beat.
- LdmRegD  output  4  register number for the current beat.
- LdmBeatD  output  BEATW  index of the current beat (0-based).
- LdmFirstD  output  1  current beat is the first.
- LdmLastD  output  1  current beat is the last.
- LdmWbD  output  1  base writeback is due on this beat (W bit set and last beat).

Behaviour:
- Block-transfer detect: `isBT = armD & validD & (instrD[27:25]==3'b100)`.
- Two states:
  - IDLE: source mask `src = instrD[15:0]`.
  - BUSY: `src = rem`, the registered remaining mask.
- Combinational outputs:
  - `LdmActiveD = isBT & (src != 0)`.
  - `LdmRegD` = index of the lowest set bit of `src`; 0 when `src == 0`.
  - `ldmStall = LdmActiveD & (popcount(src) > 1)`.
  - `LdmFirstD = LdmActiveD & (state == IDLE)`.
  - `LdmLastD = LdmActiveD & ~ldmStall`.
  - `LdmWbD = LdmLastD & instrD[21]`.
  - `LdmBeatD = (state == IDLE) ? 0 : beat`.
- Advance, on a clk edge with `~StallD & ~FlushD & LdmActiveD`:
  - `rem <= src & ~onehot(LdmRegD)`.
  - `beat <= LdmBeatD + 1`.
  - `state <= ldmStall ? BUSY : IDLE`.
- StallD high: state, `rem` and `beat` hold; outputs stay stable as long as `instrD` is stable.
- FlushD high, any state: `state <= IDLE`, `rem <= 0`, `beat <= 0`. The flush aborts any sequence in progress and takes priority over StallD.
- BUSY while `isBT` is low (mode change or invalidation): return to IDLE next cycle. Outputs are forced inactive that cycle.
- Empty register list: `LdmActiveD = 0`, no stall, no state change (treated as a no-op by this block).
- Single register: one beat, with First = Last = 1 and `ldmStall = 0`.
- Full list (0xFFFF): 16 beats, registers 0..15 ascending, `ldmStall` high for beats 0..14, `LdmBeatD` reaches 15.
- Reset: `state = IDLE`, `rem = 0`, `beat = 0`. With `validD = 0` or `armD = 0`, every output is 0. Reset mid-sequence aborts it on that edge.
- Latency:
  - First beat is visible in the same cycle the instruction enters D (zero-cycle).
  - An N-register transfer occupies D for exactly N unstalled cycles.

Test Plan:
- LDM R0,{R1,R3,R5} (instrD=0xE890002A, armD=1, validD=1, no stalls) -> three cycles, in order:
  - cycle 1: LdmRegD=1, ldmStall=1, Beat=0, First=1.
  - cycle 2: LdmRegD=3, ldmStall=1, Beat=1.
  - cycle 3: LdmRegD=5, ldmStall=0, Beat=2, Last=1.
  - then IDLE.
- Single register 0xE8900001 -> one cycle with LdmRegD=0, First=1, Last=1, ldmStall=0. Same bits with 0xE8B00001 (W=1) -> LdmWbD=1.
- Empty list 0xE8900000; also armD=0 with 0xE890002A -> LdmActiveD=0, ldmStall=0, state stays IDLE.
- 0xE890002A with StallD=1 for 3 cycles at beat 1 -> LdmRegD=3 and Beat=1 held through the stall. Resumes with R5 / Beat=2 after StallD drops.
- Abort cases:
  - FlushD=1 at beat 1 of 0xE890002A -> next cycle IDLE, rem=0. New instr 0xE8900010 gives LdmRegD=4, Beat=0, First=1.
  - rst=1 mid-sequence -> same abort result.
- Full list 0xE890FFFF -> 16 beats, registers 0..15, ldmStall=1 for the first 15 beats, Last=1 only on register 15.
